// File: rtl/uart_reg_bridge.sv
// Byte-framed host command bridge: parses UART read/write frames into register
// accesses and serialises the reply (ACK byte or 4 read-data bytes) back to uart_tx.
module uart_reg_bridge #(
   parameter int unsigned TIMEOUT_CYC = 600000,
   parameter logic [7:0]  ACK_BYTE    = 8'h06
) (
   input  logic        clk60,
   input  logic        rst,
   input  logic [7:0]  rxData,
   input  logic        rxValid,
   output logic        rxack,
   output logic [7:0]  txData,
   output logic        txSend,
   input  logic        txBusy,
   output logic        we,
   output logic [6:0]  addr,
   output logic [31:0] wdat,
   input  logic [31:0] rdat
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      StIdle,
      StGetData,
      StWrite,
      StRdLatch,
      StTxByte,
      StTxWait
   } state_e;

   state_e        state_q, state_d;
   logic          rxack_q, rxack_d;
   logic          txsend_q, txsend_d;
   logic [7:0]    txdata_q, txdata_d;
   logic          we_q, we_d;
   logic [6:0]    addr_q, addr_d;
   logic [31:0]   wdat_q, wdat_d;
   logic [31:0]   shift_q, shift_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          byte_take;

   // A byte is taken only once: the cycle rxack is high the source still shows it.
   assign byte_take = rxValid && !rxack_q;

   always_comb begin
      state_d  = state_q;
      rxack_d  = 1'b0;
      txsend_d = 1'b0;
      we_d     = 1'b0;
      txdata_d = txdata_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      bcnt_d   = bcnt_q;
      tmo_d    = tmo_q;
      unique case (state_q)
         StIdle: begin
            if (byte_take) begin
               rxack_d = 1'b1;
               addr_d  = rxData[6:0];
               if (rxData[7]) begin
                  state_d = StGetData;
                  bcnt_d  = 2'd0;
                  tmo_d   = '0;
               end else begin
                  state_d = StRdLatch;
               end
            end
         end
         StGetData: begin
            // Expiry wins over a same-cycle byte; that byte becomes the next header.
            if (tmo_q >= TW'(TIMEOUT_CYC)) begin
               state_d = StIdle;
            end else if (byte_take) begin
               rxack_d = 1'b1;
               wdat_d  = {wdat_q[23:0], rxData};
               tmo_d   = '0;
               bcnt_d  = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) state_d = StWrite;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StWrite: begin
            we_d    = 1'b1;
            shift_d = {ACK_BYTE, 24'h0};
            cnt_d   = 3'd1;
            state_d = StTxByte;
         end
         StRdLatch: begin
            shift_d = rdat;
            cnt_d   = 3'd4;
            state_d = StTxByte;
         end
         StTxByte: begin
            txdata_d = shift_q[31:24];
            txsend_d = 1'b1;
            shift_d  = {shift_q[23:0], 8'h00};
            cnt_d    = cnt_q - 3'd1;
            state_d  = StTxWait;
         end
         StTxWait: begin
            // txBusy may still be low in the txSend cycle itself.
            if (!txsend_q && !txBusy) begin
               state_d = (cnt_q != 3'd0) ? StTxByte : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk60) begin
      if (rst) begin
         state_q  <= StIdle;
         rxack_q  <= 1'b0;
         txsend_q <= 1'b0;
         txdata_q <= 8'h00;
         we_q     <= 1'b0;
         addr_q   <= 7'h00;
         wdat_q   <= 32'h0;
         shift_q  <= 32'h0;
         cnt_q    <= 3'd0;
         bcnt_q   <= 2'd0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         rxack_q  <= rxack_d;
         txsend_q <= txsend_d;
         txdata_q <= txdata_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdat_q   <= wdat_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         bcnt_q   <= bcnt_d;
         tmo_q    <= tmo_d;
      end
   end

   assign rxack  = rxack_q;
   assign txSend = txsend_q;
   assign txData = txdata_q;
   assign we     = we_q;
   assign addr   = addr_q;
   assign wdat   = wdat_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: directed frames push expected tx bytes and
// register writes; a monitor pops and compares on every txSend / we pulse.
module tb_uart_reg_bridge;

   localparam int unsigned TMO   = 1000;
   localparam int unsigned FRAME = 20;

   logic        clk60 = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rxData = 8'h00;
   logic        rxValid = 1'b0;
   logic        rxack;
   logic [7:0]  txData;
   logic        txSend;
   logic        txBusy;
   logic        we;
   logic [6:0]  addr;
   logic [31:0] wdat;
   logic [31:0] rdat;

   int tests = 0;
   int fails = 0;
   logic [7:0]  exp_tx[$];
   logic [38:0] exp_wr[$];
   logic [31:0] regs[128];
   int unsigned busy_cnt = 0;
   logic        we_prev = 1'b0;

   uart_reg_bridge #(
      .TIMEOUT_CYC (TMO),
      .ACK_BYTE    (8'h06)
   ) dut (
      .clk60   (clk60),
      .rst     (rst),
      .rxData  (rxData),
      .rxValid (rxValid),
      .rxack   (rxack),
      .txData  (txData),
      .txSend  (txSend),
      .txBusy  (txBusy),
      .we      (we),
      .addr    (addr),
      .wdat    (wdat),
      .rdat    (rdat)
   );

   always #5 clk60 = ~clk60;

   // uart_tx stand-in: busy for FRAME cycles starting the cycle after txSend.
   always @(posedge clk60) begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      else if (txSend) busy_cnt <= FRAME;
   end
   assign txBusy = (busy_cnt != 0);

   // Register file stand-in with combinational read.
   always @(posedge clk60) begin
      if (rst) begin
         regs[1]     <= 32'h0;
         regs[2]     <= 32'hCAFE0002;
         regs[7'h7F] <= 32'hDEADC0DE;
      end else if (we) begin
         regs[addr] <= wdat;
      end
   end
   assign rdat = regs[addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting, got no event expected event", name);
   endtask

   // Monitor: pops expectations whenever the DUT presents txSend or we.
   always @(posedge clk60) begin
      #1;
      if (txSend) begin
         if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_txsend: got %0h expected no txSend", txData);
         end else begin
            check("tx_byte", {56'h0, txData}, {56'h0, exp_tx.pop_front()});
         end
      end
      if (we) begin
         if (exp_wr.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_we: got %0h/%0h expected no we", addr, wdat);
         end else begin
            check("write", {25'h0, addr, wdat}, {25'h0, exp_wr.pop_front()});
         end
         check("we_exclusive", {62'h0, txSend, rxack}, 64'h0);
      end
      if (we_prev) check("we_then_txsend", {63'h0, txSend}, 64'h1);
      we_prev = we;
   end

   task automatic send_byte(input logic [7:0] b, input int unsigned bound);
      int unsigned n;
      n = 0;
      rxData  = b;
      rxValid = 1'b1;
      forever begin
         @(negedge clk60);
         if (rxack) break;
         n++;
         if (n > bound) begin
            bound_fail("rxack_wait");
            break;
         end
      end
      rxValid = 1'b0;
   endtask

   task automatic drain(input int unsigned bound);
      int unsigned n;
      n = 0;
      forever begin
         @(negedge clk60);
         if (exp_tx.size() == 0 && !txBusy) break;
         n++;
         if (n > bound) begin
            bound_fail("reply_drain");
            break;
         end
      end
      repeat (10) @(negedge clk60);
   endtask

   initial begin
      int unsigned seen;
      int unsigned n;
      repeat (3) @(negedge clk60);
      check("rst_rxack", {63'h0, rxack}, 64'h0);
      check("rst_txsend", {63'h0, txSend}, 64'h0);
      check("rst_txdata", {56'h0, txData}, 64'h0);
      check("rst_we", {63'h0, we}, 64'h0);
      check("rst_addr", {57'h0, addr}, 64'h0);
      check("rst_wdat", {32'h0, wdat}, 64'h0);
      rst = 1'b0;
      @(negedge clk60);

      // Write 0x000186A0 to register 1, expect ACK.
      exp_wr.push_back({7'h01, 32'h000186A0});
      exp_tx.push_back(8'h06);
      send_byte(8'h81, 100);
      send_byte(8'h00, 100);
      send_byte(8'h01, 100);
      send_byte(8'h86, 100);
      send_byte(8'hA0, 100);
      drain(500);

      // Read register 1 back.
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h01);
      exp_tx.push_back(8'h86);
      exp_tx.push_back(8'hA0);
      send_byte(8'h01, 100);
      drain(500);

      // Unmapped address reads whatever rdat presents.
      exp_tx.push_back(8'hDE);
      exp_tx.push_back(8'hAD);
      exp_tx.push_back(8'hC0);
      exp_tx.push_back(8'hDE);
      send_byte(8'h7F, 100);
      drain(500);

      // Partial write abandoned by timeout; register 2 keeps its value.
      send_byte(8'h82, 100);
      send_byte(8'h12, 100);
      repeat (TMO + 100) @(negedge clk60);
      exp_tx.push_back(8'hCA);
      exp_tx.push_back(8'hFE);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h02);
      send_byte(8'h02, 100);
      drain(500);

      // Back-to-back write then read; read header waits for the ACK to finish.
      exp_wr.push_back({7'h01, 32'h00000010});
      exp_tx.push_back(8'h06);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h10);
      send_byte(8'h81, 100);
      send_byte(8'h00, 100);
      send_byte(8'h00, 100);
      send_byte(8'h00, 100);
      send_byte(8'h10, 100);
      send_byte(8'h01, 300);
      check("hdr_ack_after_ack_tx", {63'h0, txBusy}, 64'h0);
      check("ack_sent_before_hdr", 64'(exp_tx.size()), 64'd4);
      drain(500);

      // Reset right after the 2nd read byte goes out.
      exp_tx.push_back(8'hDE);
      exp_tx.push_back(8'hAD);
      send_byte(8'h7F, 100);
      seen = 0;
      n = 0;
      while (seen < 2) begin
         if (txSend) seen++;
         if (seen < 2) begin
            @(negedge clk60);
            n++;
            if (n > 500) begin
               bound_fail("second_txsend");
               break;
            end
         end
      end
      rst = 1'b1;
      @(negedge clk60);
      rst = 1'b0;
      check("mid_rst_rxack", {63'h0, rxack}, 64'h0);
      check("mid_rst_txsend", {63'h0, txSend}, 64'h0);
      check("mid_rst_txdata", {56'h0, txData}, 64'h0);
      check("mid_rst_we", {63'h0, we}, 64'h0);
      check("mid_rst_addr", {57'h0, addr}, 64'h0);
      check("mid_rst_wdat", {32'h0, wdat}, 64'h0);
      repeat (60) @(negedge clk60);
      exp_tx.push_back(8'hCA);
      exp_tx.push_back(8'hFE);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h02);
      send_byte(8'h02, 100);
      drain(500);

      check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
      check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command bridge between the UART pair (`uart_rx` / `uart_tx`, CLKDIV 60) and the 7-bit-address, 32-bit register file in the top level. It parses framed read and write commands from the host. It drives single-cycle register writes, or latches a register read. It then serialises the reply back through `uart_tx`.

## Interface
Parameters:
- TIMEOUT_CYC, 600000, inter-byte timeout in clk60 cycles (10 ms at 60 MHz); partial frame discarded on expiry
- ACK_BYTE, 8'h06, reply byte sent after a completed write

Ports:
- clk60  in  1  system clock, 60 MHz
- rst  in  1  reset, synchronous, active-high
- rxData  in  8  received byte from uart_rx, valid while rxValid high
- rxValid  in  1  uart_rx has an unconsumed byte; held until rxack
- rxack  out  1  one-cycle pulse: byte consumed
- txData  out  8  byte to transmit, stable from txSend until txBusy falls
- txSend  out  1  one-cycle start pulse to uart_tx
- txBusy  in  1  uart_tx busy; rises no later than one cycle after txSend
- we  out  1  one-cycle register write strobe
- addr  out  7  register address
- wdat  out  32  write data, valid while we high
- rdat  in  32  combinational read data for addr

## Operation
- Frame: header byte {rw, addr[6:0]}; rw=1 write, rw=0 read.
- Write frame: header + 4 data bytes, MSB first. Reply: ACK_BYTE.
- Read frame: header only. Reply: 4 bytes of rdat, MSB first.
- States: IDLE, GET_DATA, WRITE, RD_LATCH, TX_BYTE, TX_WAIT.
- IDLE: on rxValid, consume the byte and load addr. rw=1 -> GET_DATA with byte count 0. rw=0 -> RD_LATCH.
- GET_DATA: each consumed byte shifts into wdat ({wdat[23:0], byte}). The 4th byte -> WRITE. The timeout counter clears on every consumed byte. At TIMEOUT_CYC cycles with no byte -> IDLE, no we, wdat content discarded.
- WRITE: we=1 for exactly one cycle. Load the tx shift register with {ACK_BYTE, 24'h0} and set the remaining count to 1. -> TX_BYTE.
- RD_LATCH: capture rdat (addr has been stable for ≥1 cycle) into the 32-bit shift register and set the count to 4. -> TX_BYTE.
- TX_BYTE: txData = shift[31:24]; txSend=1 for one cycle; shift left by 8; decrement count. -> TX_WAIT.
- TX_WAIT: ignore txBusy on the first cycle after txSend. Afterwards, when txBusy=0: count>0 -> TX_BYTE, else -> IDLE.
- rxack: asserted only in IDLE/GET_DATA. It is gated by !rxack, so one byte is never consumed twice. Bytes arriving during WRITE/RD_LATCH/TX_* are not acked; uart_rx holds them until IDLE.
- Addresses are not range-checked. Any addr is forwarded, and reads return whatever rdat presents.
- Reset values: state IDLE, rxack=0, txSend=0, txData=8'h00, we=0, addr=7'h00, wdat=32'h0, counters 0.
- rst mid-frame or mid-reply: abort immediately, no we and no further txSend. A byte already in flight in uart_tx completes under uart_tx's own reset rules.

## Timing
- Byte consume: rxValid sampled high at cycle C -> rxack=1 and byte registered at C+1.
- Write: 4th data byte sampled at C -> rxack at C+1 -> we=1 with final wdat/addr at C+2 -> txSend (ACK_BYTE) at C+3.
- Read: header sampled at C -> addr valid at C+1 -> rdat latched at C+2 -> first txSend at C+3.
- Inter-byte txSend spacing equals uart_tx frame time plus 2 cycles.
- Timeout counter saturates. Expiry takes priority over a byte arriving in the same cycle; that byte is then treated as a new header in IDLE.
- we never coincides with txSend, and never with rxack.

## Test plan
- Write: send 81 00 01 86 A0 -> single we pulse, addr=7'h01, wdat=32'h000186A0; host receives 06.
- Read: send 01 with rdat(0x01)=32'h000186A0 -> host receives 00 01 86 A0 in order; no we.
- Unmapped read: send 7F with rdat=32'hDEADC0DE -> host receives DE AD C0 DE.
- Timeout: send 82 12, then idle > TIMEOUT_CYC (use TIMEOUT_CYC=1000 in sim) -> no we. Then send 02 -> 4-byte reply of register 0x02.
- Back-to-back: send 81 00 00 00 10 and 01 with no gap -> we with wdat=32'h10, reply 06. Then the read reply 00 00 00 10; the read header is not acked before the 06 transmission completes.
- Reset mid-reply: assert rst for 1 cycle after the 2nd read byte's txSend -> no further txSend, all outputs at reset values next cycle. A new read then works normally.
